// File: rtl/codasip_init_pkg.sv
// Shared constants for the post-reset initialisation sequencer.
//   INIT_ST_W  : width of the sequencer state register
//   init_st_e  : sequencer states (IDLE, CLEAR, WAIT_MEM, RUN)
//   TMO_W      : width of the mem_ready timeout counter
package codasip_init_pkg;

    localparam int INIT_ST_W = 2;
    localparam int TMO_W     = 8;

    typedef enum logic [INIT_ST_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_RUN      = 2'd3
    } init_st_e;

endpackage

// File: rtl/d_ff_rst_t.sv
// Generic resettable register.
//   clk : clock, rising edge
//   rst : reset, polarity RESET_LEVEL, synchronous when RESET_SYNC=1
//   d   : next value
//   q   : registered value, RESET_VAL while reset is active
module d_ff_rst_t #(
    parameter int               WIDTH       = 1,
    parameter bit               RESET_LEVEL = 1'b0,
    parameter bit               RESET_SYNC  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (RESET_SYNC) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst == RESET_LEVEL) q <= RESET_VAL;
                else                    q <= d;
            end
        end else if (RESET_LEVEL == 1'b0) begin : g_async_lo
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) q <= RESET_VAL;
                else      q <= d;
            end
        end else begin : g_async_hi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= RESET_VAL;
                else     q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/codasip_init_seq_t.sv
// Post-reset initialisation sequencer. On reset_ACT it clears the register
// file through a dedicated write port, waits for mem_ready, strobes the boot
// PC and then releases the core (core_run follows main_ACT only in RUN).
//   CLK, RST (sync, active low)
//   reset_ACT, main_ACT, mem_ready        : startup controller / memory inputs
//   rf_we, rf_addr, rf_wd                 : register-file clear port
//   pc_load, pc_value                     : boot PC load strobe and value
//   core_run, init_done, init_err         : core release and status
module codasip_init_seq_t
    import codasip_init_pkg::*;
#(
    parameter int                   RF_ADDR_W   = 5,
    parameter int                   RF_DATA_W   = 32,
    parameter logic [RF_DATA_W-1:0] BOOT_ADDR   = '0,
    parameter int                   SKIP_X0     = 1,
    parameter int                   MEM_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 reset_ACT,
    input  logic                 main_ACT,
    input  logic                 mem_ready,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_addr,
    output logic [RF_DATA_W-1:0] rf_wd,
    output logic                 pc_load,
    output logic [RF_DATA_W-1:0] pc_value,
    output logic                 core_run,
    output logic                 init_done,
    output logic                 init_err
);

    localparam logic [RF_ADDR_W-1:0] ADDR_FIRST = (SKIP_X0 != 0) ? RF_ADDR_W'(1) : '0;
    localparam logic [RF_ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [TMO_W-1:0]     TMO_LIMIT  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_MAX    = '1;

    logic [INIT_ST_W-1:0] state_q, state_d;
    logic [RF_ADDR_W-1:0] addr_q,  addr_d;
    logic [TMO_W-1:0]     tmo_q,   tmo_d, tmo_inc;
    logic                 err_q,   err_d;

    d_ff_rst_t #(.WIDTH(INIT_ST_W), .RESET_LEVEL(1'b0), .RESET_SYNC(1'b1)) u_state (
        .clk(CLK), .rst(RST), .d(state_d), .q(state_q));
    d_ff_rst_t #(.WIDTH(RF_ADDR_W), .RESET_LEVEL(1'b0), .RESET_SYNC(1'b1)) u_addr (
        .clk(CLK), .rst(RST), .d(addr_d), .q(addr_q));
    d_ff_rst_t #(.WIDTH(TMO_W), .RESET_LEVEL(1'b0), .RESET_SYNC(1'b1)) u_tmo (
        .clk(CLK), .rst(RST), .d(tmo_d), .q(tmo_q));
    d_ff_rst_t #(.WIDTH(1), .RESET_LEVEL(1'b0), .RESET_SYNC(1'b1)) u_err (
        .clk(CLK), .rst(RST), .d(err_d), .q(err_q));

    // Saturating increment: the counter parks at its maximum so a long wait
    // can never wrap below the timeout threshold.
    assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wd     = '0;
        pc_load   = 1'b0;
        pc_value  = '0;
        core_run  = 1'b0;
        init_done = 1'b0;

        case (init_st_e'(state_q))
            ST_CLEAR: begin
                rf_we   = 1'b1;
                rf_addr = addr_q;
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_WAIT_MEM;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ready) begin
                    // A simultaneous restart suppresses the boot strobe.
                    pc_load  = !reset_ACT;
                    pc_value = reset_ACT ? '0 : BOOT_ADDR;
                    state_d  = ST_RUN;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc >= TMO_LIMIT) err_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                core_run  = main_ACT;
            end
            default: ;
        endcase

        // Restart has priority over every transition; init_err is kept as-is.
        if (reset_ACT) begin
            state_d = ST_CLEAR;
            addr_d  = ADDR_FIRST;
            tmo_d   = '0;
            err_d   = err_q;
        end
    end

    assign init_err = err_q;

endmodule

// File: tb/tb_codasip_init_seq_t.sv
module tb_codasip_init_seq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ra, ma, mr;

    logic        we0, pl0, cr0, dn0, er0;
    logic [4:0]  ad0;
    logic [31:0] wd0, pv0;
    logic        we1, pl1, cr1, dn1, er1;
    logic [2:0]  ad1;
    logic [31:0] wd1, pv1;

    localparam logic [31:0] BOOT1 = 32'h8000_0040;

    codasip_init_seq_t u_dut0 (
        .CLK(clk), .RST(rst), .reset_ACT(ra), .main_ACT(ma), .mem_ready(mr),
        .rf_we(we0), .rf_addr(ad0), .rf_wd(wd0), .pc_load(pl0), .pc_value(pv0),
        .core_run(cr0), .init_done(dn0), .init_err(er0));

    codasip_init_seq_t #(.RF_ADDR_W(3), .RF_DATA_W(32), .BOOT_ADDR(BOOT1),
                         .SKIP_X0(0), .MEM_TIMEOUT(20)) u_dut1 (
        .CLK(clk), .RST(rst), .reset_ACT(ra), .main_ACT(ma), .mem_ready(mr),
        .rf_we(we1), .rf_addr(ad1), .rf_wd(wd1), .pc_load(pl1), .pc_value(pv1),
        .core_run(cr1), .init_done(dn1), .init_err(er1));

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a clearing pass walks a position over the table,
    // then the sequencer waits for memory, then it runs.
    int          N_ENT [2] = '{32, 8};
    int          SKIP  [2] = '{1, 0};
    int          TOUT  [2] = '{255, 20};
    logic [31:0] BOOT  [2] = '{32'h0, BOOT1};

    bit m_clr [2];
    bit m_wait[2];
    bit m_run [2];
    int m_pos [2];
    int m_wcnt[2];
    bit m_err [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_clr[k] = 0; m_wait[k] = 0; m_run[k] = 0;
            m_pos[k] = 0; m_wcnt[k] = 0; m_err[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit c, w, r, e;
            int p, n;
            c = m_clr[k]; w = m_wait[k]; r = m_run[k];
            p = m_pos[k]; n = m_wcnt[k]; e = m_err[k];
            if (!rst) begin
                c = 0; w = 0; r = 0; p = 0; n = 0; e = 0;
            end else if (ra) begin
                c = 1; w = 0; r = 0; p = SKIP[k]; n = 0;
            end else if (c) begin
                if (p == N_ENT[k] - 1) begin c = 0; w = 1; p = 0; end
                else p = p + 1;
            end else if (w) begin
                if (mr) begin w = 0; r = 1; n = 0; end
                else begin
                    n = (n < 255) ? n + 1 : 255;
                    if (n >= TOUT[k]) e = 1;
                end
            end
            m_clr[k] <= c; m_wait[k] <= w; m_run[k] <= r;
            m_pos[k] <= p; m_wcnt[k] <= n; m_err[k] <= e;
        end
    end

    task automatic cmp_inst(input int k, input logic we, input logic [31:0] ad,
                            input logic [31:0] wd, input logic pl, input logic [31:0] pv,
                            input logic cr, input logic dn, input logic er);
        bit epl;
        epl = m_wait[k] && mr && !ra;
        chk($sformatf("u%0d.rf_we", k),     {31'b0, we}, {31'b0, m_clr[k]});
        chk($sformatf("u%0d.rf_addr", k),   ad, m_clr[k] ? m_pos[k] : 0);
        chk($sformatf("u%0d.rf_wd", k),     wd, 32'h0);
        chk($sformatf("u%0d.pc_load", k),   {31'b0, pl}, {31'b0, epl});
        chk($sformatf("u%0d.pc_value", k),  pv, epl ? BOOT[k] : 32'h0);
        chk($sformatf("u%0d.core_run", k),  {31'b0, cr}, {31'b0, m_run[k] && ma});
        chk($sformatf("u%0d.init_done", k), {31'b0, dn}, {31'b0, m_run[k]});
        chk($sformatf("u%0d.init_err", k),  {31'b0, er}, {31'b0, m_err[k]});
    endtask

    always @(negedge clk) begin
        #2;
        if (checking) begin
            cmp_inst(0, we0, {27'b0, ad0}, wd0, pl0, pv0, cr0, dn0, er0);
            cmp_inst(1, we1, {29'b0, ad1}, wd1, pl1, pv1, cr1, dn1, er1);
        end
    end

    task automatic step(input logic r, input logic a, input logic m, input logic y);
        @(negedge clk);
        rst = r; ra = a; ma = m; mr = y;
        #2;
    endtask

    initial begin
        rst = 1'b0; ra = 1'b0; ma = 1'b0; mr = 1'b0;

        // Reset held three cycles
        step(0, 0, 0, 0);
        checking = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset rf_we", {31'b0, we0}, 0);
        chk("reset init_done", {31'b0, dn0}, 0);
        chk("reset init_err", {31'b0, er0}, 0);
        chk("reset core_run", {31'b0, cr0}, 0);

        // Nominal bring-up, mem_ready already high
        step(1, 1, 0, 1);
        for (int c = 1; c <= 40; c++) begin
            step(1, 0, 1, 1);
            if (c == 1)  begin chk("t1 addr first", ad0, 1); chk("t1 we first", {31'b0, we0}, 1); end
            if (c == 31) chk("t1 addr last", ad0, 31);
            if (c == 32) begin chk("t1 pc_load", {31'b0, pl0}, 1); chk("t1 pc_value", pv0, 0);
                               chk("t1 run early", {31'b0, cr0}, 0); end
            if (c == 33) chk("t1 core_run", {31'b0, cr0}, 1);
            if (c == 1)  chk("t2 addr first", ad1, 0);
            if (c == 8)  chk("t2 addr last", ad1, 7);
            if (c == 9)  begin chk("t2 no wrap", {31'b0, we1}, 0); chk("t2 pc_load", {31'b0, pl1}, 1);
                               chk("t2 pc_value", pv1, BOOT1); end
        end

        // main_ACT low while running
        step(1, 0, 0, 1);
        chk("t6 core_run off", {31'b0, cr0}, 0);
        chk("t6 init_done", {31'b0, dn0}, 1);

        // Restart from RUN
        step(1, 1, 1, 1);
        for (int c = 1; c <= 40; c++) begin
            step(1, 0, 1, 1);
            if (c == 1)  begin chk("t5 core_run drop", {31'b0, cr0}, 0); chk("t5 addr", ad0, 1); end
            if (c == 33) chk("t5 rerun", {31'b0, cr0}, 1);
        end

        // Memory timeout
        step(1, 1, 1, 0);
        for (int c = 1; c <= 302; c++) begin
            step(1, 0, 1, (c >= 300));
            if (c == 286) chk("t3 err early", {31'b0, er0}, 0);
            if (c == 287) chk("t3 err set", {31'b0, er0}, 1);
            if (c == 28)  chk("t3 u1 err early", {31'b0, er1}, 0);
            if (c == 29)  chk("t3 u1 err set", {31'b0, er1}, 1);
            if (c == 299) chk("t3 no run", {31'b0, cr0}, 0);
            if (c == 300) chk("t3 pc_load", {31'b0, pl0}, 1);
            if (c == 301) begin chk("t3 run", {31'b0, cr0}, 1); chk("t3 err sticky", {31'b0, er0}, 1); end
        end

        // reset_ACT and mem_ready together in WAIT_MEM
        step(1, 1, 1, 0);
        for (int c = 1; c <= 32; c++) step(1, 0, 1, 0);
        chk("t6 waiting", {31'b0, we0}, 0);
        step(1, 1, 1, 1);
        chk("t6 pc_load suppressed", {31'b0, pl0}, 0);
        step(1, 0, 1, 1);
        chk("t6 restart we", {31'b0, we0}, 1);
        chk("t6 restart addr", ad0, 1);

        // RST mid-clear
        for (int c = 2; c <= 9; c++) step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("t4 addr 10", ad0, 10);
        step(1, 0, 1, 1);
        chk("t4 we off", {31'b0, we0}, 0);
        chk("t4 addr 0", ad0, 0);
        chk("t4 err clr", {31'b0, er0}, 0);
        chk("t4 done off", {31'b0, dn0}, 0);
        step(1, 1, 1, 1);
        step(1, 0, 1, 1);
        chk("t4 restart addr", ad0, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) < ((c / 500) % 2 == 0 ? 1 : 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
